piradip_axis_gain_ramp: RTL and testbench
=========================================

PIRADIP_AXIS_GAIN_RAMP -- requirements
Module: piradip_axis_gain_ramp

Interface
REQ-001 Parameter SAMPLE_WIDTH, default 16, SHALL set the signed sample width.
REQ-002 Parameter NSAMPLES, default 4, SHALL set the number of samples packed per beat (tdata width = SAMPLE_WIDTH*NSAMPLES).
REQ-003 Parameter GAIN_WIDTH, default 18, SHALL set the signed gain width.
REQ-004 Parameter FRACTIONAL_WIDTH, default 14, SHALL set the number of gain fraction bits (>=1).
REQ-005 Port aclk, input, 1, SHALL be the single clock for all logic.
REQ-006 Port aresetn, input, 1, SHALL be the reset: asynchronous assert, active-low.
REQ-007 Ports s_axis_tdata/tvalid/tlast (in), s_axis_tready (out) SHALL be the input stream.
REQ-008 Ports m_axis_tdata/tvalid/tlast (out), m_axis_tready (in) SHALL be the output stream.
REQ-009 Ports wren (in, 1), wreg_no (in, 3), wreg_data (in, 32) SHALL be the register write port (one write per asserted cycle).
REQ-010 Ports rreg_no (in, 3), rreg_data (out, 32) SHALL be the combinational register read port.

Function
REQ-011 Registers SHALL be: 0 ID (RO, 0x50534752); 1 TARGET (RW, GAIN_WIDTH signed); 2 STEP (RW, unsigned GAIN_WIDTH-1 bits); 3 CURRENT (RO); 4 SATCNT (RO, 32-bit; any write clears). Unmapped reads SHALL return 0.
REQ-012 Each sample SHALL compute y = sat(((x*g) + 2^(FRACTIONAL_WIDTH-1)) >>> FRACTIONAL_WIDTH): full-width signed product, round half toward +inf, arithmetic shift.
REQ-013 Saturation SHALL clamp to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1]; SATCNT SHALL add the number of clamped samples in each emitted beat, saturating at 0xFFFFFFFF.
REQ-014 Each beat SHALL use the CURRENT gain value sampled at its input handshake; all NSAMPLES lanes use the same gain.
REQ-015 On every input handshake CURRENT SHALL move toward TARGET by STEP, clamping exactly at TARGET; STEP=0 SHALL load TARGET immediately.
REQ-016 A TARGET write mid-ramp SHALL retarget from the present CURRENT with no jump; CURRENT SHALL not change on cycles without an input handshake.
REQ-017 Write to SATCNT on the same cycle as an increment SHALL clear (clear wins).
REQ-018 Datapath SHALL be a 3-stage pipeline (register, multiply, round/saturate); latency input handshake -> m_axis_tvalid = 3 cycles when unstalled.
REQ-019 Pipeline SHALL advance when m_axis_tready=1 or stage-3 valid=0; s_axis_tready SHALL equal that advance term.
REQ-020 tlast SHALL travel with its beat; no beat SHALL be dropped, duplicated or reordered under any tready pattern.
REQ-021 Full throughput SHALL be one beat per cycle with tready held high.

Reset
REQ-022 During reset: all stage valids, m_axis_tvalid, m_axis_tlast, SATCNT = 0; m_axis_tdata = 0; TARGET = CURRENT = 2^FRACTIONAL_WIDTH; STEP = 0.
REQ-023 s_axis_tready SHALL be 0 while aresetn=0; beats in flight at reset SHALL be discarded.

Structure
REQ-024 Register indices, ID constant and a signed-saturate function SHALL live in package piradip_gain_pkg.
REQ-025 One per-lane sub-module piradip_gain_lane (multiply, round, saturate, sat flag, stage enable) SHALL be instantiated NSAMPLES times; ramp control and registers SHALL stay in the top.

Verification
REQ-026 Unity gain (16384), input 0x1234 tlast=1 -> 0x1234 tlast=1 on output 3 cycles later.
REQ-027 TARGET=32768, STEP=0, samples 0x7000, 0x9000 -> 0x7FFF, 0x8000; SATCNT=2.
REQ-028 TARGET=8192, samples 3 and -3 -> 2 and -1 (round half up).
REQ-029 CURRENT=16384, TARGET=0, STEP=4096, five beats of 1000 -> 1000, 750, 500, 250, 0; CURRENT ends 0.
REQ-030 Continuous random input, m_axis_tready low 10 cycles then random -> scoreboard exact match, s_axis_tready low when pipe full.
REQ-031 aresetn pulsed low mid-stream -> outputs idle, registers at REQ-022 values, next beat processed at unity gain.

Source files
------------

// File: rtl/piradip_gain_pkg.sv
// Shared constants and helpers for the AXI-Stream gain-ramp block:
// register map, ID word and a generic signed saturator.
package piradip_gain_pkg;

  localparam logic [2:0]  REG_ID      = 3'd0;
  localparam logic [2:0]  REG_TARGET  = 3'd1;
  localparam logic [2:0]  REG_STEP    = 3'd2;
  localparam logic [2:0]  REG_CURRENT = 3'd3;
  localparam logic [2:0]  REG_SATCNT  = 3'd4;

  localparam logic [31:0] GAIN_ID = 32'h5053_4752;

  // Clamp a sign-extended value to the range of a w-bit signed number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int unsigned       w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 32'd1));
    if (v > hi) begin
      r = hi;
    end else if (v < lo) begin
      r = lo;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/piradip_gain_lane.sv
// One sample lane: input register, full-width multiply, then round/saturate.
// All three stages advance together on en_i.
module piradip_gain_lane
  import piradip_gain_pkg::*;
#(
  parameter int SAMPLE_WIDTH     = 16,
  parameter int GAIN_WIDTH       = 18,
  parameter int FRACTIONAL_WIDTH = 14
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           en_i,
  input  logic signed [SAMPLE_WIDTH-1:0] x_i,
  input  logic signed [GAIN_WIDTH-1:0]   g_i,
  output logic signed [SAMPLE_WIDTH-1:0] y_o,
  output logic                           sat_o
);

  localparam int PW = SAMPLE_WIDTH + GAIN_WIDTH;
  localparam logic signed [PW:0] HALF_C = {{PW{1'b0}}, 1'b1} << (FRACTIONAL_WIDTH - 1);

  logic signed [SAMPLE_WIDTH-1:0] x_q;
  logic signed [GAIN_WIDTH-1:0]   g_q;
  logic signed [PW-1:0]           prod_q;
  logic signed [PW-1:0]           prod_d;
  logic signed [PW-1:0]           xe_s;
  logic signed [PW-1:0]           ge_s;
  logic signed [PW:0]             rnd_s;
  logic signed [PW:0]             sh_s;
  logic signed [63:0]             wide_s;
  logic signed [63:0]             clamp_s;
  logic signed [SAMPLE_WIDTH-1:0] y_q;
  logic signed [SAMPLE_WIDTH-1:0] y_d;
  logic                           sat_q;
  logic                           sat_d;

  // Multiply in PW bits so the product can never wrap; the extra rounding
  // bit keeps the +half from overflowing at the most positive product.
  always_comb begin
    xe_s    = {{GAIN_WIDTH{x_q[SAMPLE_WIDTH-1]}}, x_q};
    ge_s    = {{SAMPLE_WIDTH{g_q[GAIN_WIDTH-1]}}, g_q};
    prod_d  = xe_s * ge_s;
    rnd_s   = {prod_q[PW-1], prod_q} + HALF_C;
    sh_s    = rnd_s >>> FRACTIONAL_WIDTH;
    wide_s  = {{(63 - PW){sh_s[PW]}}, sh_s};
    clamp_s = sat_signed(wide_s, SAMPLE_WIDTH);
    y_d     = clamp_s[SAMPLE_WIDTH-1:0];
    sat_d   = (clamp_s != wide_s);
  end

  // Three pipeline stages held as a unit while the output is stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q    <= {SAMPLE_WIDTH{1'b0}};
      g_q    <= {GAIN_WIDTH{1'b0}};
      prod_q <= {PW{1'b0}};
      y_q    <= {SAMPLE_WIDTH{1'b0}};
      sat_q  <= 1'b0;
    end else if (en_i) begin
      x_q    <= x_i;
      g_q    <= g_i;
      prod_q <= prod_d;
      y_q    <= y_d;
      sat_q  <= sat_d;
    end else begin
      x_q    <= x_q;
      g_q    <= g_q;
      prod_q <= prod_q;
      y_q    <= y_q;
      sat_q  <= sat_q;
    end
  end

  assign y_o   = y_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/piradip_axis_gain_ramp.sv
// AXI-Stream gain stage with a ramped gain: every accepted beat uses the
// current gain, which then steps toward the programmed target.
module piradip_axis_gain_ramp
  import piradip_gain_pkg::*;
#(
  parameter int SAMPLE_WIDTH     = 16,
  parameter int NSAMPLES         = 4,
  parameter int GAIN_WIDTH       = 18,
  parameter int FRACTIONAL_WIDTH = 14
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [SAMPLE_WIDTH*NSAMPLES-1:0] s_axis_tdata,
  input  logic                             s_axis_tvalid,
  input  logic                             s_axis_tlast,
  output logic                             s_axis_tready,
  output logic [SAMPLE_WIDTH*NSAMPLES-1:0] m_axis_tdata,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tlast,
  input  logic                             m_axis_tready,
  input  logic                             wren,
  input  logic [2:0]                       wreg_no,
  input  logic [31:0]                      wreg_data,
  input  logic [2:0]                       rreg_no,
  output logic [31:0]                      rreg_data
);

  localparam int SCW = $clog2(NSAMPLES + 1) + 1;
  localparam logic signed [GAIN_WIDTH-1:0] UNITY_C =
    {{(GAIN_WIDTH-1){1'b0}}, 1'b1} << FRACTIONAL_WIDTH;

  logic                           adv_s;
  logic                           hs_s;
  logic                           emit_s;
  logic                           v1_q, v2_q, v3_q;
  logic                           last1_q, last2_q, last3_q;
  logic signed [GAIN_WIDTH-1:0]   tgt_q, tgt_d;
  logic signed [GAIN_WIDTH-1:0]   cur_q, cur_d;
  logic [GAIN_WIDTH-2:0]          step_q, step_d;
  logic [31:0]                    satcnt_q, satcnt_d;
  logic signed [GAIN_WIDTH:0]     cur_x_s, tgt_x_s, step_x_s, diff_s, sum_s;
  logic [NSAMPLES-1:0]            sat_s;
  logic [SCW-1:0]                 popcnt_s;
  logic [32:0]                    sat_sum_s;
  logic signed [SAMPLE_WIDTH-1:0] y_s [NSAMPLES];
  logic                           unused_s;

  assign adv_s         = m_axis_tready | ~v3_q;
  assign s_axis_tready = adv_s & aresetn;
  assign hs_s          = s_axis_tvalid & s_axis_tready;
  assign emit_s        = v3_q & m_axis_tready;
  assign unused_s      = ^{wreg_data[31:GAIN_WIDTH], sum_s[GAIN_WIDTH]};

  for (genvar i = 0; i < NSAMPLES; i++) begin : g_lane
    piradip_gain_lane #(
      .SAMPLE_WIDTH     (SAMPLE_WIDTH),
      .GAIN_WIDTH       (GAIN_WIDTH),
      .FRACTIONAL_WIDTH (FRACTIONAL_WIDTH)
    ) u_lane (
      .clk_i  (aclk),
      .rst_ni (aresetn),
      .en_i   (adv_s),
      .x_i    (s_axis_tdata[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
      .g_i    (cur_q),
      .y_o    (y_s[i]),
      .sat_o  (sat_s[i])
    );
    assign m_axis_tdata[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = y_s[i];
  end

  // Next gain: one STEP toward TARGET, landing exactly on it when within reach.
  always_comb begin
    cur_x_s  = {cur_q[GAIN_WIDTH-1], cur_q};
    tgt_x_s  = {tgt_q[GAIN_WIDTH-1], tgt_q};
    step_x_s = {2'b00, step_q};
    diff_s   = tgt_x_s - cur_x_s;
    sum_s    = cur_x_s;
    if (~|step_q) begin
      sum_s = tgt_x_s;
    end else if (diff_s > step_x_s) begin
      sum_s = cur_x_s + step_x_s;
    end else if (diff_s < -step_x_s) begin
      sum_s = cur_x_s - step_x_s;
    end else begin
      sum_s = tgt_x_s;
    end
    cur_d = hs_s ? sum_s[GAIN_WIDTH-1:0] : cur_q;
  end

  // Register-port writes; a ramp in progress continues from CURRENT.
  always_comb begin
    tgt_d  = tgt_q;
    step_d = step_q;
    if (wren && (wreg_no == REG_TARGET)) begin
      tgt_d = wreg_data[GAIN_WIDTH-1:0];
    end else if (wren && (wreg_no == REG_STEP)) begin
      step_d = wreg_data[GAIN_WIDTH-2:0];
    end else begin
      tgt_d  = tgt_q;
      step_d = step_q;
    end
  end

  // Saturation counter: adds clamped lanes of each emitted beat; a write clears.
  always_comb begin
    popcnt_s = {SCW{1'b0}};
    for (int i = 0; i < NSAMPLES; i++) begin
      popcnt_s = popcnt_s + {{(SCW-1){1'b0}}, sat_s[i]};
    end
    sat_sum_s = {1'b0, satcnt_q} + {{(33-SCW){1'b0}}, popcnt_s};
    satcnt_d  = satcnt_q;
    if (wren && (wreg_no == REG_SATCNT)) begin
      satcnt_d = 32'h0000_0000;
    end else if (emit_s) begin
      satcnt_d = sat_sum_s[32] ? 32'hFFFF_FFFF : sat_sum_s[31:0];
    end else begin
      satcnt_d = satcnt_q;
    end
  end

  // Combinational register read mux.
  always_comb begin
    case (rreg_no)
      REG_ID:      rreg_data = GAIN_ID;
      REG_TARGET:  rreg_data = {{(32-GAIN_WIDTH){tgt_q[GAIN_WIDTH-1]}}, tgt_q};
      REG_STEP:    rreg_data = {{(33-GAIN_WIDTH){1'b0}}, step_q};
      REG_CURRENT: rreg_data = {{(32-GAIN_WIDTH){cur_q[GAIN_WIDTH-1]}}, cur_q};
      REG_SATCNT:  rreg_data = satcnt_q;
      default:     rreg_data = 32'h0000_0000;
    endcase
  end

  // Control registers and gain state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tgt_q    <= UNITY_C;
      cur_q    <= UNITY_C;
      step_q   <= {(GAIN_WIDTH-1){1'b0}};
      satcnt_q <= 32'h0000_0000;
    end else begin
      tgt_q    <= tgt_d;
      cur_q    <= cur_d;
      step_q   <= step_d;
      satcnt_q <= satcnt_d;
    end
  end

  // Beat valid/tlast tracking, moving in lockstep with the lane stages.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
      last3_q <= 1'b0;
    end else if (adv_s) begin
      v1_q    <= hs_s;
      v2_q    <= v1_q;
      v3_q    <= v2_q;
      last1_q <= s_axis_tlast & hs_s;
      last2_q <= last1_q;
      last3_q <= last2_q;
    end else begin
      v1_q    <= v1_q;
      v2_q    <= v2_q;
      v3_q    <= v3_q;
      last1_q <= last1_q;
      last2_q <= last2_q;
      last3_q <= last3_q;
    end
  end

  assign m_axis_tvalid = v3_q;
  assign m_axis_tlast  = last3_q;

endmodule

// File: tb/tb_piradip_axis_gain_ramp.sv
// Bench for piradip_axis_gain_ramp: an arithmetic reference model with a
// scoreboard, plus directed beats with hand-computed results.
module tb_piradip_axis_gain_ramp;

  localparam int SW = 16;
  localparam int NS = 4;
  localparam int GW = 18;
  localparam int FW = 14;
  localparam int TW = SW * NS;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [TW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [TW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic          wren;
  logic [2:0]    wreg_no, rreg_no;
  logic [31:0]   wreg_data, rreg_data;

  always #5 aclk = ~aclk;

  piradip_axis_gain_ramp #(
    .SAMPLE_WIDTH(SW), .NSAMPLES(NS), .GAIN_WIDTH(GW), .FRACTIONAL_WIDTH(FW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .wren(wren), .wreg_no(wreg_no), .wreg_data(wreg_data),
    .rreg_no(rreg_no), .rreg_data(rreg_data)
  );

  typedef struct {
    logic [TW-1:0] data;
    logic          last;
    int            nsat;
  } exp_t;

  exp_t          exp_q[$];
  logic [TW-1:0] obs_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  longint        m_tgt, m_cur, m_step, m_sat;
  logic          hs_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: y = clamp(floor((x*g + 2^(FW-1)) / 2^FW)) per lane.
  function automatic exp_t model_beat(input logic [TW-1:0] d, input logic l, input longint g);
    exp_t        e;
    longint      x, r;
    logic [63:0] rb;
    e.data = '0;
    e.last = l;
    e.nsat = 0;
    for (int i = 0; i < NS; i++) begin
      x = longint'($signed(d[i*SW +: SW]));
      r = (x * g + 64'sd8192) >>> FW;
      if (r > 64'sd32767) begin
        r = 64'sd32767;
        e.nsat++;
      end else if (r < -64'sd32768) begin
        r = -64'sd32768;
        e.nsat++;
      end
      rb = r;
      e.data[i*SW +: SW] = rb[SW-1:0];
    end
    return e;
  endfunction

  function automatic longint ramp(input longint cur, input longint tgt, input longint step);
    if (step == 0) return tgt;
    if (tgt > cur) return (tgt - cur <= step) ? tgt : cur + step;
    if (tgt < cur) return (cur - tgt <= step) ? tgt : cur - step;
    return cur;
  endfunction

  function automatic logic [31:0] model_reg(input logic [2:0] n);
    logic [63:0] v;
    case (n)
      3'd0: v = 64'h5053_4752;
      3'd1: v = m_tgt;
      3'd2: v = m_step;
      3'd3: v = m_cur;
      3'd4: v = m_sat;
      default: v = 64'h0;
    endcase
    return v[31:0];
  endfunction

  // Compare process: every negedge, check outputs/regs and advance the model.
  always @(negedge aclk) begin : mon
    exp_t e;
    if (!aresetn) begin
      check("rst_s_tready", s_axis_tready, 1'b0);
      check("rst_m_tvalid", m_axis_tvalid, 1'b0);
      check("rst_m_tlast", m_axis_tlast, 1'b0);
      check("rst_m_tdata", m_axis_tdata, 64'h0);
      exp_q.delete();
      m_tgt = 16384; m_cur = 16384; m_step = 0; m_sat = 0;
    end else begin
      check("rreg", rreg_data, model_reg(rreg_no));
      check("s_tready_rule", s_axis_tready, !m_axis_tvalid || m_axis_tready);
      if (m_axis_tvalid && m_axis_tready) begin
        obs_q.push_back(m_axis_tdata);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_beat: got 0x%0h, expected no beat", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          check("tdata", m_axis_tdata, e.data);
          check("tlast", m_axis_tlast, e.last);
          m_sat = m_sat + e.nsat;
          if (m_sat > 64'sd4294967295) m_sat = 64'sd4294967295;
        end
      end
      if (wren && wreg_no == 3'd4) m_sat = 0;
      if (s_axis_tvalid && s_axis_tready) begin
        exp_q.push_back(model_beat(s_axis_tdata, s_axis_tlast, m_cur));
        m_cur = ramp(m_cur, m_tgt, m_step);
      end
      if (wren && wreg_no == 3'd1) m_tgt = longint'($signed(wreg_data[GW-1:0]));
      if (wren && wreg_no == 3'd2) m_step = longint'(wreg_data[GW-2:0]);
    end
  end

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic wr(input logic [2:0] n, input logic [31:0] d);
    tick();
    wren = 1'b1; wreg_no = n; wreg_data = d;
    tick();
    wren = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [2:0] n, input logic [31:0] exp);
    tick();
    rreg_no = n;
    #1;
    check(name, rreg_data, exp);
  endtask

  task automatic send(input logic [TW-1:0] d, input logic l);
    logic got;
    got = 1'b0;
    s_tdata_set(d, l);
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge aclk);
      got = s_axis_tready;
      @(posedge aclk); #1;
    end
    s_axis_tvalid = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got no s_axis_tready, expected handshake");
    end
  endtask

  task automatic s_tdata_set(input logic [TW-1:0] d, input logic l);
    s_axis_tdata = d; s_axis_tlast = l; s_axis_tvalid = 1'b1;
  endtask

  task automatic wait_obs(input int n, input string name);
    for (int k = 0; k < 50 && obs_q.size() < n; k++) tick();
    if (obs_q.size() < n) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: got %0d beats, expected %0d", name, obs_q.size(), n);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of run, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1; wren = 1'b0; wreg_no = 3'd0; wreg_data = 32'h0;
    rreg_no = 3'd0; aresetn = 1'b1; hs_seen = 1'b0;
    #1 aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;

    // reset values
    rd_check("rst_id", 3'd0, 32'h5053_4752);
    rd_check("rst_target", 3'd1, 32'h0000_4000);
    rd_check("rst_step", 3'd2, 32'h0000_0000);
    rd_check("rst_current", 3'd3, 32'h0000_4000);
    rd_check("rst_satcnt", 3'd4, 32'h0000_0000);
    rd_check("unmapped", 3'd6, 32'h0000_0000);

    // unity gain and 3-cycle latency
    s_tdata_set(64'h7FFF_FFFF_0001_1234, 1'b1);
    tick();
    s_axis_tvalid = 1'b0;
    check("lat_c1", m_axis_tvalid, 1'b0);
    tick();
    check("lat_c2", m_axis_tvalid, 1'b0);
    tick();
    check("lat_c3", m_axis_tvalid, 1'b1);
    check("unity_data", m_axis_tdata, 64'h7FFF_FFFF_0001_1234);
    check("unity_last", m_axis_tlast, 1'b1);

    // gain 2.0 saturates both rails
    wr(3'd4, 32'h0);
    wr(3'd1, 32'd32768);
    obs_q.delete();
    send(64'h0, 1'b0);
    send(64'h0000_0000_9000_7000, 1'b0);
    wait_obs(2, "sat_wait");
    if (obs_q.size() >= 2) check("sat_data", obs_q[1], 64'h0000_0000_8000_7FFF);
    rd_check("satcnt_2", 3'd4, 32'd2);

    // gain 0.5 rounding half up
    wr(3'd1, 32'd8192);
    obs_q.delete();
    send(64'h0, 1'b0);
    send(64'hFFFF_0001_FFFD_0003, 1'b0);
    wait_obs(2, "rnd_wait");
    if (obs_q.size() >= 2) check("round_data", obs_q[1], 64'h0000_0001_FFFF_0002);

    // ramp 1.0 -> 0 in steps of 0.25
    wr(3'd1, 32'd16384);
    send(64'h0, 1'b0);
    wr(3'd2, 32'd4096);
    wr(3'd1, 32'd0);
    obs_q.delete();
    for (int i = 0; i < 5; i++) send(64'h03E8_03E8_03E8_03E8, (i == 4));
    wait_obs(5, "ramp_wait");
    if (obs_q.size() >= 5) begin
      check("ramp_0", obs_q[0], 64'h03E8_03E8_03E8_03E8);
      check("ramp_1", obs_q[1], 64'h02EE_02EE_02EE_02EE);
      check("ramp_2", obs_q[2], 64'h01F4_01F4_01F4_01F4);
      check("ramp_3", obs_q[3], 64'h00FA_00FA_00FA_00FA);
      check("ramp_4", obs_q[4], 64'h0000_0000_0000_0000);
    end
    rd_check("ramp_cur_end", 3'd3, 32'd0);

    // retarget mid-ramp; CURRENT holds without handshakes
    wr(3'd1, 32'd16384);
    send(64'h0, 1'b0);
    rd_check("retgt_cur_a", 3'd3, 32'h0000_1000);
    repeat (3) tick();
    rd_check("retgt_hold", 3'd3, 32'h0000_1000);
    wr(3'd1, 32'hFFFF_E000);
    for (int i = 0; i < 3; i++) send(64'h0, 1'b0);
    rd_check("retgt_cur_b", 3'd3, 32'hFFFF_E000);

    // random stream with backpressure
    rreg_no = 3'd3;
    m_axis_tready = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (c == 10) check("pipe_full_tready", s_axis_tready, 1'b0);
      m_axis_tready = (c < 10) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (!s_axis_tvalid || hs_seen)
        s_tdata_set({$urandom, $urandom}, $urandom_range(0, 1) == 1);
      wren = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 2))
        0: begin wreg_no = 3'd1; wreg_data = $urandom; end
        1: begin wreg_no = 3'd2; wreg_data = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom_range(1, 9000); end
        default: begin wreg_no = 3'd4; wreg_data = 32'd0; end
      endcase
      @(negedge aclk);
      hs_seen = s_axis_tvalid && s_axis_tready;
      @(posedge aclk); #1;
    end
    s_axis_tvalid = 1'b0; wren = 1'b0; m_axis_tready = 1'b1; rreg_no = 3'd4;
    repeat (10) tick();
    check("drain_empty", exp_q.size(), 0);

    // reset with beats in flight
    wr(3'd1, 32'd20000);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) send({4{16'h0100}}, 1'b0);
    tick();
    aresetn = 1'b0;
    #1;
    check("mid_rst_tvalid", m_axis_tvalid, 1'b0);
    check("mid_rst_tdata", m_axis_tdata, 64'h0);
    repeat (2) tick();
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    rd_check("post_rst_target", 3'd1, 32'h0000_4000);
    rd_check("post_rst_current", 3'd3, 32'h0000_4000);
    rd_check("post_rst_step", 3'd2, 32'h0000_0000);
    rd_check("post_rst_satcnt", 3'd4, 32'h0000_0000);
    obs_q.delete();
    send(64'h1111_2222_3333_4444, 1'b1);
    wait_obs(1, "post_rst_wait");
    if (obs_q.size() >= 1) check("post_rst_unity", obs_q[0], 64'h1111_2222_3333_4444);
    repeat (3) tick();
    check("post_rst_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
